// File: rtl/riscv_load_pkg.sv
// Shared definitions for the load path: funct3 codes, FSM encoding and
// the lane extension / legality helpers.
package riscv_load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

    // Misaligned halfword/word or an unused funct3 encoding.
    function automatic logic load_err(input logic [2:0] f3, input logic [1:0] a);
        logic err;
        case (f3)
            F3_LB, F3_LBU: err = 1'b0;
            F3_LH, F3_LHU: err = a[0];
            F3_LW:         err = |a;
            default:       err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_align_unit_extend.sv
// load_lane_extend: picks the addressed byte/halfword of a little-endian
// word and sign- or zero-extends it to 32 bits. Purely combinational.
module load_lane_extend
    import riscv_load_pkg::*;
(
    input  logic [31:0] mem_rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sgn;

    always_comb begin
        byte_lane = mem_rdata_i[7:0];
        case (addr_i)
            2'd1:    byte_lane = mem_rdata_i[15:8];
            2'd2:    byte_lane = mem_rdata_i[23:16];
            2'd3:    byte_lane = mem_rdata_i[31:24];
            default: byte_lane = mem_rdata_i[7:0];
        endcase
        half_lane = addr_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        // funct3[2] set marks the unsigned variants
        sgn = ~funct3_i[2];
        case (funct3_i)
            F3_LB, F3_LBU: data_o = ext8(byte_lane, sgn);
            F3_LH, F3_LHU: data_o = ext16(half_lane, sgn);
            default:       data_o = mem_rdata_i;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Load align stage: issues a word read, waits MEM_LAT cycles, returns the
// extended lane. Optional LOAD_ALIGN_B2B_EN lets RESP accept the next load.
module load_align_unit
    import riscv_load_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_misaligned
);

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic [1:0]  addr_lo_q;
    logic [2:0]  f3_q;
    logic [31:0] rsp_data_q;
    logic        rsp_mis_q;

    logic        accept;
    logic        req_err;
    logic        rsp_fire;
    logic [31:0] lane_d;

`ifdef LOAD_ALIGN_B2B_EN
    assign req_ready = (state_q == S_IDLE) | ((state_q == S_RESP) & rsp_ready);
`else
    assign req_ready = (state_q == S_IDLE);
`endif

    assign rsp_valid      = (state_q == S_RESP);
    assign rsp_fire       = rsp_valid & rsp_ready;
    assign accept         = req_valid & req_ready;
    assign req_err        = load_err(req_funct3, req_addr[1:0]);
    assign mem_en         = accept & ~req_err;
    assign mem_addr       = {req_addr[31:2], 2'b00};
    assign rsp_data       = rsp_data_q;
    assign rsp_misaligned = rsp_mis_q;

    load_lane_extend u_ext (
        .mem_rdata_i (mem_rdata),
        .addr_i      (addr_lo_q),
        .funct3_i    (f3_q),
        .data_o      (lane_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            addr_lo_q  <= 2'd0;
            f3_q       <= 3'd0;
            rsp_data_q <= 32'd0;
            rsp_mis_q  <= 1'b0;
        end else if (accept) begin
            // Only reachable from IDLE, or from RESP on a retiring handshake.
            addr_lo_q <= req_addr[1:0];
            f3_q      <= req_funct3;
            if (req_err) begin
                rsp_data_q <= 32'd0;
                rsp_mis_q  <= 1'b1;
                state_q    <= S_RESP;
            end else begin
                cnt_q   <= CNT_INIT;
                state_q <= S_WAIT;
            end
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == 2'd0) begin
                        rsp_data_q <= lane_d;
                        rsp_mis_q  <= 1'b0;
                        state_q    <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_fire) state_q <= S_IDLE;
                end
                S_IDLE: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
